// File: rtl/btn_debounce_pkg.sv
// Shared definitions for the push-button debounce block.
// Holds the Gray-coded FSM state encoding and the default qualification length.
// Neighbouring states differ in one bit, so a state change flips a single flop.
package btn_debounce_pkg;

  localparam int DEFAULT_STABLE_CYCLES = 16;

  typedef enum logic [1:0] {
    ST_IDLE_LOW  = 2'b00,
    ST_WAIT_HIGH = 2'b01,
    ST_IDLE_HIGH = 2'b11,
    ST_WAIT_LOW  = 2'b10
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// Ports:
//   clk   - destination clock
//   reset - asynchronous, active-high; clears both flops to 0
//   d     - asynchronous input
//   q     - synchronised output (second flop)
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// Push-button / switch debouncer.
// Synchronises btn_raw into clk and only lets btn_level follow it after the
// synchronised value has held for STABLE_CYCLES consecutive samples.
// Ports:
//   clk       - system clock
//   reset     - asynchronous, active-high reset
//   btn_raw   - raw, bouncing, asynchronous input
//   btn_level - debounced level, registered
//   busy      - high while a candidate transition is being qualified, registered
//
// state        | meaning
// ST_IDLE_LOW  | settled low, watching for a 1
// ST_WAIT_HIGH | candidate rise, counting stable 1 samples
// ST_IDLE_HIGH | settled high, watching for a 0
// ST_WAIT_LOW  | candidate fall, counting stable 0 samples
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic busy
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sample;
  state_e           state;
  logic [CNT_W-1:0] cnt;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_raw),
    .q     (sample)
  );

  // Outputs are loaded together with the destination state so they are
  // plain flops with no decode logic in front of the downstream consumer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE_LOW;
      cnt       <= '0;
      btn_level <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE_LOW: begin
          btn_level <= 1'b0;
          if (sample) begin
            state <= ST_WAIT_HIGH;
            cnt   <= CNT_ONE;
            busy  <= 1'b1;
          end else begin
            cnt  <= '0;
            busy <= 1'b0;
          end
        end

        ST_WAIT_HIGH: begin
          // A revert is checked first so it wins over reaching the terminal count.
          if (!sample) begin
            state     <= ST_IDLE_LOW;
            cnt       <= '0;
            btn_level <= 1'b0;
            busy      <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state     <= ST_IDLE_HIGH;
            cnt       <= '0;
            btn_level <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt       <= cnt + CNT_ONE;
            btn_level <= 1'b0;
            busy      <= 1'b1;
          end
        end

        ST_IDLE_HIGH: begin
          btn_level <= 1'b1;
          if (!sample) begin
            state <= ST_WAIT_LOW;
            cnt   <= CNT_ONE;
            busy  <= 1'b1;
          end else begin
            cnt  <= '0;
            busy <= 1'b0;
          end
        end

        ST_WAIT_LOW: begin
          if (sample) begin
            state     <= ST_IDLE_HIGH;
            cnt       <= '0;
            btn_level <= 1'b1;
            busy      <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state     <= ST_IDLE_LOW;
            cnt       <= '0;
            btn_level <= 1'b0;
            busy      <= 1'b0;
          end else begin
            cnt       <= cnt + CNT_ONE;
            btn_level <= 1'b1;
            busy      <= 1'b1;
          end
        end

        default: begin
          state     <= ST_IDLE_LOW;
          cnt       <= '0;
          btn_level <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
module tb_btn_debounce;

  localparam int SC = 4;

  logic clk = 1'b0;
  logic reset;
  logic btn_raw;
  logic btn_level;
  logic busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  btn_debounce #(.STABLE_CYCLES(SC)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .busy      (busy)
  );

  // Drive one input value, let one rising edge pass, then sit 1 time unit after it.
  task automatic step(input logic v);
    btn_raw = v;
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input logic v, input int n);
    for (int i = 0; i < n; i++) step(v);
  endtask

  task automatic test_reset;
    logic el, eb;
    reset = 1'b1;
    btn_raw = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step(1'b1);
      checks++;
      if ({btn_level, busy} !== 2'b00) begin
        errors++;
        $display("FAIL reset_hold step %0d level/busy=%b%b expected 00", k, btn_level, busy);
      end
    end
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step(1'b1);
      el = (k >= 6);
      eb = (k >= 3 && k <= 5);
      checks++;
      if ({btn_level, busy} !== {el, eb}) begin
        errors++;
        $display("FAIL reset_release step %0d level/busy=%b%b expected %b%b", k, btn_level, busy, el, eb);
      end
    end
  endtask

  task automatic test_release;
    logic el, eb;
    for (int k = 1; k <= 8; k++) begin
      step(1'b0);
      el = (k < 6);
      eb = (k >= 3 && k <= 5);
      checks++;
      if ({btn_level, busy} !== {el, eb}) begin
        errors++;
        $display("FAIL release step %0d level/busy=%b%b expected %b%b", k, btn_level, busy, el, eb);
      end
    end
  endtask

  task automatic test_release_glitch;
    logic [0:8] raw = 9'b001000000;
    logic [0:8] xl  = 9'b111111110;
    logic [0:8] xb  = 9'b001101110;
    settle(1'b1, 8);
    for (int k = 0; k < 9; k++) begin
      step(raw[k]);
      checks++;
      if ({btn_level, busy} !== {xl[k], xb[k]}) begin
        errors++;
        $display("FAIL release_glitch step %0d level/busy=%b%b expected %b%b", k + 1, btn_level, busy, xl[k], xb[k]);
      end
    end
  endtask

  task automatic test_clean_press;
    logic el, eb;
    for (int k = 1; k <= 10; k++) begin
      step(1'b1);
      el = (k >= 6);
      eb = (k >= 3 && k <= 5);
      checks++;
      if ({btn_level, busy} !== {el, eb}) begin
        errors++;
        $display("FAIL clean_press step %0d level/busy=%b%b expected %b%b", k, btn_level, busy, el, eb);
      end
    end
    settle(1'b0, 8);
    checks++;
    if ({btn_level, busy} !== 2'b00) begin
      errors++;
      $display("FAIL clean_press_return level/busy=%b%b expected 00", btn_level, busy);
    end
  endtask

  task automatic test_bounce;
    logic [0:12] raw = 13'b1110110111111;
    logic [0:12] xl  = 13'b0000000000001;
    logic [0:12] xb  = 13'b0011101101110;
    for (int k = 0; k < 13; k++) begin
      step(raw[k]);
      checks++;
      if ({btn_level, busy} !== {xl[k], xb[k]}) begin
        errors++;
        $display("FAIL bounce step %0d level/busy=%b%b expected %b%b", k + 1, btn_level, busy, xl[k], xb[k]);
      end
    end
    settle(1'b0, 8);
  endtask

  task automatic test_threshold;
    logic [0:9]  raw_a = 10'b1110000000;
    logic [0:9]  xb_a  = 10'b0011100000;
    logic [0:11] raw_b = 12'b111100000000;
    logic [0:11] xl_b  = 12'b000001111000;
    logic [0:11] xb_b  = 12'b001110111000;
    logic prev;
    int rises = 0;
    for (int k = 0; k < 10; k++) begin
      step(raw_a[k]);
      checks++;
      if ({btn_level, busy} !== {1'b0, xb_a[k]}) begin
        errors++;
        $display("FAIL threshold_3 step %0d level/busy=%b%b expected 0%b", k + 1, btn_level, busy, xb_a[k]);
      end
    end
    prev = btn_level;
    for (int k = 0; k < 12; k++) begin
      step(raw_b[k]);
      if (btn_level === 1'b1 && prev === 1'b0) rises++;
      prev = btn_level;
      checks++;
      if ({btn_level, busy} !== {xl_b[k], xb_b[k]}) begin
        errors++;
        $display("FAIL threshold_4 step %0d level/busy=%b%b expected %b%b", k + 1, btn_level, busy, xl_b[k], xb_b[k]);
      end
    end
    checks++;
    if (rises !== 1) begin
      errors++;
      $display("FAIL threshold_4_rises got %0d expected 1", rises);
    end
  endtask

  task automatic test_reset_mid_wait;
    logic el, eb;
    for (int k = 1; k <= 4; k++) step(1'b1);
    checks++;
    if ({btn_level, busy} !== 2'b01) begin
      errors++;
      $display("FAIL mid_wait_high_pre level/busy=%b%b expected 01", btn_level, busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({btn_level, busy} !== 2'b00) begin
      errors++;
      $display("FAIL mid_wait_high_reset level/busy=%b%b expected 00", btn_level, busy);
    end
    step(1'b1);
    step(1'b1);
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step(1'b1);
      el = (k >= 6);
      eb = (k >= 3 && k <= 5);
      checks++;
      if ({btn_level, busy} !== {el, eb}) begin
        errors++;
        $display("FAIL mid_wait_high_requal step %0d level/busy=%b%b expected %b%b", k, btn_level, busy, el, eb);
      end
    end
    for (int k = 1; k <= 4; k++) step(1'b0);
    checks++;
    if ({btn_level, busy} !== 2'b11) begin
      errors++;
      $display("FAIL mid_wait_low_pre level/busy=%b%b expected 11", btn_level, busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({btn_level, busy} !== 2'b00) begin
      errors++;
      $display("FAIL mid_wait_low_reset level/busy=%b%b expected 00", btn_level, busy);
    end
    step(1'b0);
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step(1'b0);
      checks++;
      if ({btn_level, busy} !== 2'b00) begin
        errors++;
        $display("FAIL mid_wait_low_after step %0d level/busy=%b%b expected 00", k, btn_level, busy);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    btn_raw = 1'b0;
    test_reset();
    test_release();
    test_release_glitch();
    test_clean_press();
    test_bounce();
    test_threshold();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
